// File: rtl/dtc_share_sched_if.sv
// dtc_share_sched_if: request/response bundle between the requesters, the
// shared combinational classifier and the dtc_share_sched scheduler.
// The slave modport is the scheduler's view; the master modport is the
// environment (requesters, classifier, downstream consumer).
// Parameters must match the ones given to the dtc_share_sched instance.
`timescale 1ns/1ps

interface dtc_share_sched_if #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 12,
    parameter int CLS_W = 3
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*IN_W-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic [IN_W-1:0]      cls_inp;
    logic [CLS_W-1:0]     cls_outp;
    logic                 rsp_valid;
    logic [CLS_W-1:0]     rsp_class;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_ready;

    modport master (
        output req_valid, req_data, cls_outp, rsp_ready,
        input  req_ready, cls_inp, rsp_valid, rsp_class, rsp_id
    );

    modport slave (
        input  req_valid, req_data, cls_outp, rsp_ready,
        output req_ready, cls_inp, rsp_valid, rsp_class, rsp_id
    );
endinterface

// File: rtl/dtc_share_sched.sv
// dtc_share_sched: time-shares one combinational classifier among NREQ
// requesters. A round-robin arbiter grants one requester, its feature vector
// is registered onto cls_inp, the class code is captured one cycle later and
// held on the response port until the downstream handshake.
// Optional build macro DTC_SHARE_SCHED_STATS_EN adds per-class saturating
// 16-bit response counters on output stat_cnt.
// NREQ must be a power of two between 2 and 8 (the arbiter pointer wraps by
// natural overflow of its log2(NREQ)-bit width).
`timescale 1ns/1ps

module dtc_share_sched #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 12,
    parameter int CLS_W = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dtc_share_sched_if.slave            bus
`ifdef DTC_SHARE_SCHED_STATS_EN
    ,
    output logic [(2**CLS_W)*16-1:0]    stat_cnt
`endif
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [IN_W-1:0]    cls_inp_q,    cls_inp_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic [CLS_W-1:0]   rsp_class_q,  rsp_class_d;
    logic [ID_W-1:0]    rsp_id_q,     rsp_id_d;

    logic               any_req;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    arb_cand;
    logic               grant;
    logic               rsp_hs;
    logic [NREQ-1:0]    req_ready_c;

    // Round-robin search: first active requester after the last grant, wrapping.
    always_comb begin
        any_req  = 1'b0;
        win_idx  = last_grant_q;
        arb_cand = last_grant_q;
        for (int k = 1; k <= NREQ; k++) begin
            arb_cand = last_grant_q + ID_W'(k);
            if (!any_req && bus.req_valid[arb_cand]) begin
                any_req = 1'b1;
                win_idx = arb_cand;
            end
        end
    end

    // Response handshake only exists while a result is being held.
    assign rsp_hs = (state_q == HOLD) && rsp_valid_q && bus.rsp_ready;

    // Next-state and datapath updates; a grant is suppressed while reset is low
    // so no accept strobe escapes during reset.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cls_inp_d    = cls_inp_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_class_d  = rsp_class_q;
        rsp_id_d     = rsp_id_q;
        grant        = 1'b0;
        req_ready_c  = '0;

        case (state_q)
            IDLE: begin
                grant = any_req;
            end
            EVAL: begin
                // cls_inp was loaded last cycle, so cls_outp is settled now;
                // last_grant still names the requester that owns it.
                rsp_valid_d = 1'b1;
                rsp_class_d = bus.cls_outp;
                rsp_id_d    = last_grant_q;
                state_d     = HOLD;
            end
            HOLD: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    grant       = any_req;
                    if (!any_req) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        grant = grant && rst_n;

        if (grant) begin
            last_grant_d = win_idx;
            state_d      = EVAL;
            for (int i = 0; i < NREQ; i++) begin
                if (ID_W'(i) == win_idx) begin
                    req_ready_c[i] = 1'b1;
                    cls_inp_d      = bus.req_data[i*IN_W +: IN_W];
                end
            end
        end
    end

    // State, arbiter pointer and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            cls_inp_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_class_q  <= '0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cls_inp_q    <= cls_inp_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_class_q  <= rsp_class_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.cls_inp   = cls_inp_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_class = rsp_class_q;
    assign bus.rsp_id    = rsp_id_q;

`ifdef DTC_SHARE_SCHED_STATS_EN
    localparam int NCLS = 2**CLS_W;

    // Packed so that counter k lands in bits [k*16 +: 16] of stat_cnt.
    logic [NCLS-1:0][15:0] stat_q, stat_d;

    // Bump the counter for the class being handed off, sticking at all-ones.
    always_comb begin
        stat_d = stat_q;
        if (rsp_hs && (stat_q[rsp_class_q] != 16'hFFFF)) begin
            stat_d[rsp_class_q] = stat_q[rsp_class_q] + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule
